// File: rtl/score_arb_pkg.sv
// Shared types and defaults for the score write arbiter.
// Holds the arbiter state encoding, default parameter values and the hit popcount helper.
package score_arb_pkg;

  typedef enum logic {
    READY   = 1'b0,
    CONSUME = 1'b1
  } arb_state_t;

  localparam int         N_REQ_DEF        = 4;
  localparam int         PEND_W_DEF       = 8;
  localparam logic [4:0] SCORE_REG_DEF    = 5'd30;
  localparam int         STARVE_LIMIT_DEF = 7;

  // Number of set bits among the lowest n bits of v (n <= 32).
  function automatic logic [5:0] popcount(input logic [31:0] v, input int n);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      if ((i < n) && v[i]) c = c + 6'd1;
    end
    return c;
  endfunction

endpackage

// File: rtl/score_accum.sv
// Saturating accumulator of hit pulses.
// A take empties the current pending value in the same cycle that new hits are added,
// so hits arriving on a take cycle land in the fresh total. Overflow is sticky until reset.
module score_accum import score_arb_pkg::*; #(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_REQ-1:0]  i_hit,
  input  logic              i_take,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overflow
);

  localparam int SUM_W = PEND_W + 7;
  localparam logic [SUM_W-1:0] MAX_VAL = {{(SUM_W-PEND_W){1'b0}}, {PEND_W{1'b1}}};

  logic [PEND_W-1:0] r_pending;
  logic              r_overflow;
  logic [31:0]       w_hit_ext;
  logic [5:0]        w_cnt;
  logic [SUM_W-1:0]  w_base;
  logic [SUM_W-1:0]  w_sum;
  logic              w_clip;

  // Next total: what is left after an optional take, plus this cycle's hits.
  always_comb begin
    w_hit_ext              = '0;
    w_hit_ext[N_REQ-1:0]   = i_hit;
    w_cnt                  = popcount(w_hit_ext, N_REQ);
    w_base                 = i_take ? '0 : {{(SUM_W-PEND_W){1'b0}}, r_pending};
    w_sum                  = w_base + {{(SUM_W-6){1'b0}}, w_cnt};
    w_clip                 = (w_sum > MAX_VAL);
  end

  // Register the clipped total and latch overflow whenever hits had to be dropped.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending <= w_clip ? {PEND_W{1'b1}} : w_sum[PEND_W-1:0];
      if (w_clip) r_overflow <= 1'b1;
    end
  end

  assign o_pending  = r_pending;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/score_write_arbiter.sv
// Regfile write-port arbiter between the CPU and accumulated game hits.
// Injects the pending delta into SCORE_REG on CPU-idle cycles, or steals a slot by
// stalling the CPU once it has blocked delivery for STARVE_LIMIT cycles, then waits
// for the CPU to write SCORE_REG (consume) before offering another delta.
// Optional build macro: SCORE_ARB_STATS_EN adds grant/steal counters.
module score_write_arbiter import score_arb_pkg::*; #(
  parameter int         N_REQ        = N_REQ_DEF,
  parameter int         PEND_W       = PEND_W_DEF,
  parameter logic [4:0] SCORE_REG    = SCORE_REG_DEF,
  parameter int         STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_REQ-1:0]  i_hit,
  input  logic              i_cpu_we,
  input  logic [4:0]        i_cpu_rd,
  input  logic [31:0]       i_cpu_wdata,
  output logic              o_rf_we,
  output logic [4:0]        o_rf_rd,
  output logic [31:0]       o_rf_wdata,
  output logic              o_cpu_stall,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_busy,
`ifdef SCORE_ARB_STATS_EN
  output logic [15:0]       o_grant_cnt,
  output logic [15:0]       o_steal_cnt,
`endif
  output logic              o_overflow
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_t          r_state;
  arb_state_t          w_state_next;
  logic [STARVE_W-1:0] r_starve;
  logic [STARVE_W-1:0] w_starve_next;
  logic                w_grant;
  logic [PEND_W-1:0]   w_pending;
  logic                w_overflow;

  score_accum #(
    .N_REQ  (N_REQ),
    .PEND_W (PEND_W)
  ) u_accum (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_hit      (i_hit),
    .i_take     (w_grant),
    .o_pending  (w_pending),
    .o_overflow (w_overflow)
  );

  // Grant when a delta is waiting and either the CPU is idle or it has starved us long enough.
  always_comb begin
    w_grant = i_reset && (r_state == READY) && (w_pending != '0) &&
              (!i_cpu_we || (r_starve == STARVE_MAX));
  end

  // Write-port mux: injected delta on grant, otherwise zero-latency CPU pass-through.
  always_comb begin
    o_rf_we     = i_cpu_we;
    o_rf_rd     = i_cpu_rd;
    o_rf_wdata  = i_cpu_wdata;
    o_cpu_stall = 1'b0;
    if (w_grant) begin
      o_rf_we     = 1'b1;
      o_rf_rd     = SCORE_REG;
      o_rf_wdata  = {{(32-PEND_W){1'b0}}, w_pending};
      o_cpu_stall = i_cpu_we;
    end
  end

  // Next state: hold the written delta until the CPU writes SCORE_REG back.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      READY:   if (w_grant) w_state_next = CONSUME;
      CONSUME: if (i_cpu_we && (i_cpu_rd == SCORE_REG)) w_state_next = READY;
      default: w_state_next = READY;
    endcase
  end

  // Starvation counter: counts blocked READY cycles, saturating at the steal threshold.
  always_comb begin
    w_starve_next = r_starve;
    if (w_grant || (w_pending == '0)) begin
      w_starve_next = '0;
    end else if ((r_state == READY) && i_cpu_we && (r_starve != STARVE_MAX)) begin
      w_starve_next = r_starve + STARVE_W'(1);
    end
  end

  // State and starvation registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state  <= READY;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_next;
      r_starve <= w_starve_next;
    end
  end

`ifdef SCORE_ARB_STATS_EN
  logic [15:0] r_grant_cnt;
  logic [15:0] r_steal_cnt;

  // Wrapping counters of all grants and of grants that stalled the CPU.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_grant_cnt <= '0;
      r_steal_cnt <= '0;
    end else if (w_grant) begin
      r_grant_cnt <= r_grant_cnt + 16'd1;
      if (i_cpu_we) r_steal_cnt <= r_steal_cnt + 16'd1;
    end
  end

  assign o_grant_cnt = r_grant_cnt;
  assign o_steal_cnt = r_steal_cnt;
`endif

  assign o_pending  = w_pending;
  assign o_overflow = w_overflow;
  assign o_busy     = (r_state == CONSUME);

endmodule
